// File: rtl/view_angle_ctrl.sv
// Camera orientation controller: accumulates yaw/pitch deltas, applies them once
// per frame, waits for the lookat datapath to settle, then publishes the view.
module view_angle_ctrl #(
    parameter int YAW_MOD       = 360,
    parameter int PITCH_MAX     = 89,
    parameter int PITCH_MIN     = -89,
    parameter int SETTLE_CYCLES = 4,
    parameter int YAW_INIT      = 0,
    parameter int PITCH_INIT    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [7:0]  in_dyaw,
    input  logic signed [7:0]  in_dpitch,
    input  logic               frame_start,
    output logic signed [15:0] angle_x,
    output logic signed [15:0] angle_y,
    input  logic signed [15:0] rel_x,
    input  logic signed [15:0] rel_y,
    input  logic signed [15:0] rel_z,
    input  logic signed [15:0] rel_h_x,
    input  logic signed [15:0] rel_h_y,
    output logic signed [15:0] view_x,
    output logic signed [15:0] view_y,
    output logic signed [15:0] view_z,
    output logic signed [15:0] view_h_x,
    output logic signed [15:0] view_h_y,
    output logic               view_valid,
    input  logic               view_ready,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SETTLE,
        PUBLISH
    } state_t;

    state_t state;
    state_t state_nx;

    logic signed [9:0]  pend_yaw;
    logic signed [8:0]  pend_pitch;
    logic               dirty;
    logic [3:0]         cnt;
    logic               accept;

    logic signed [10:0] yaw_acc;
    logic signed [9:0]  yaw_sat;
    logic signed [9:0]  pitch_acc;
    logic signed [8:0]  pitch_sat;

    logic signed [16:0] ys;
    logic signed [16:0] yw;
    logic signed [16:0] ps;
    logic signed [15:0] yaw_nx;
    logic signed [15:0] pitch_nx;

    assign in_ready = (state != APPLY);
    assign busy     = (state != IDLE);
    assign accept   = in_valid & in_ready;

    // Pending deltas saturate silently; any motion beyond the limits is dropped.
    always_comb begin
        yaw_acc = {pend_yaw[9], pend_yaw} + {{3{in_dyaw[7]}}, in_dyaw};
        yaw_sat = yaw_acc[9:0];
        if (yaw_acc > 11'sd359) begin
            yaw_sat = 10'sd359;
        end else if (yaw_acc < -11'sd359) begin
            yaw_sat = -10'sd359;
        end
    end

    always_comb begin
        pitch_acc = {pend_pitch[8], pend_pitch} + {{2{in_dpitch[7]}}, in_dpitch};
        pitch_sat = pitch_acc[8:0];
        if (pitch_acc > 10'sd180) begin
            pitch_sat = 9'sd180;
        end else if (pitch_acc < -10'sd180) begin
            pitch_sat = -9'sd180;
        end
    end

    // Yaw sum lies in -359..718, so a single add or subtract of YAW_MOD wraps it.
    always_comb begin
        ys = {angle_x[15], angle_x} + {{7{pend_yaw[9]}}, pend_yaw};
        yw = ys;
        if (ys >= YAW_MOD) begin
            yw = ys - 17'(YAW_MOD);
        end else if (ys < 0) begin
            yw = ys + 17'(YAW_MOD);
        end
        yaw_nx = yw[15:0];
    end

    always_comb begin
        ps = {angle_y[15], angle_y} + {{8{pend_pitch[8]}}, pend_pitch};
        pitch_nx = ps[15:0];
        if (ps > PITCH_MAX) begin
            pitch_nx = 16'(PITCH_MAX);
        end else if (ps < PITCH_MIN) begin
            pitch_nx = 16'(PITCH_MIN);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (frame_start && dirty) begin
                    state_nx = APPLY;
                end
            end
            APPLY: begin
                state_nx = SETTLE;
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    state_nx = PUBLISH;
                end
            end
            PUBLISH: begin
                if (view_valid && view_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            angle_x    <= 16'(YAW_INIT);
            angle_y    <= 16'(PITCH_INIT);
            pend_yaw   <= '0;
            pend_pitch <= '0;
            dirty      <= 1'b1;
            cnt        <= '0;
        end else if (state == APPLY) begin
            angle_x    <= yaw_nx;
            angle_y    <= pitch_nx;
            pend_yaw   <= '0;
            pend_pitch <= '0;
            dirty      <= 1'b0;
            cnt        <= 4'(SETTLE_CYCLES - 1);
        end else begin
            if (accept) begin
                pend_yaw   <= yaw_sat;
                pend_pitch <= pitch_sat;
                dirty      <= 1'b1;
            end
            if (state == SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // The datapath is a multicycle path; sample it only once the settle window ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            view_x     <= '0;
            view_y     <= '0;
            view_z     <= '0;
            view_h_x   <= '0;
            view_h_y   <= '0;
            view_valid <= 1'b0;
        end else begin
            if (state == SETTLE && cnt == 4'd0) begin
                view_x     <= rel_x;
                view_y     <= rel_y;
                view_z     <= rel_z;
                view_h_x   <= rel_h_x;
                view_h_y   <= rel_h_y;
                view_valid <= 1'b1;
            end else if (state == PUBLISH && view_ready) begin
                view_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_view_angle_ctrl.sv
// Scoreboard bench for view_angle_ctrl: directed deltas and frames, a monitor
// compares each published view against the queued expectation.
module tb_view_angle_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_dyaw;
    logic signed [7:0]  in_dpitch;
    logic               frame_start;
    logic signed [15:0] angle_x;
    logic signed [15:0] angle_y;
    logic signed [15:0] rel_x;
    logic signed [15:0] rel_y;
    logic signed [15:0] rel_z;
    logic signed [15:0] rel_h_x;
    logic signed [15:0] rel_h_y;
    logic signed [15:0] view_x;
    logic signed [15:0] view_y;
    logic signed [15:0] view_z;
    logic signed [15:0] view_h_x;
    logic signed [15:0] view_h_y;
    logic               view_valid;
    logic               view_ready;
    logic               busy;

    typedef struct {
        int ax;
        int ay;
        int vx;
        int vy;
        int vz;
        int hx;
        int hy;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   k = 0;
    int   last_vx = 0;

    view_angle_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dyaw     (in_dyaw),
        .in_dpitch   (in_dpitch),
        .frame_start (frame_start),
        .angle_x     (angle_x),
        .angle_y     (angle_y),
        .rel_x       (rel_x),
        .rel_y       (rel_y),
        .rel_z       (rel_z),
        .rel_h_x     (rel_h_x),
        .rel_h_y     (rel_h_y),
        .view_x      (view_x),
        .view_y      (view_y),
        .view_z      (view_z),
        .view_h_x    (view_h_x),
        .view_h_y    (view_h_y),
        .view_valid  (view_valid),
        .view_ready  (view_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int dy, input int dp);
        in_valid  = 1'b1;
        in_dyaw   = 8'(dy);
        in_dpitch = 8'(dp);
        tick();
        in_valid  = 1'b0;
    endtask

    // Issue a frame and push the view the datapath inputs should yield.
    task automatic frame(input int ax, input int ay, input bit hold);
        exp_t e;
        int   n;
        k++;
        e.ax = ax;
        e.ay = ay;
        e.vx = k * 100 + 1;
        e.vy = -(k * 100 + 2);
        e.vz = k * 37 - 500;
        e.hx = k * 11 + 7;
        e.hy = -(k * 13);
        rel_x   = 16'(e.vx);
        rel_y   = 16'(e.vy);
        rel_z   = 16'(e.vz);
        rel_h_x = 16'(e.hx);
        rel_h_y = 16'(e.hy);
        last_vx = e.vx;
        sb.push_back(e);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n = 0;
        while (!view_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", n, 5);
        if (!hold) begin
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && view_valid && view_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_view: got view_x %0d expected none",
                         view_x);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("angle_x", int'(angle_x), e.ax);
                chk("angle_y", int'(angle_y), e.ay);
                chk("view_x", int'(view_x), e.vx);
                chk("view_y", int'(view_y), e.vy);
                chk("view_z", int'(view_z), e.vz);
                chk("view_h_x", int'(view_h_x), e.hx);
                chk("view_h_y", int'(view_h_y), e.hy);
            end
        end
    end

    initial begin
        int vcnt;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_dyaw     = '0;
        in_dpitch   = '0;
        frame_start = 1'b0;
        view_ready  = 1'b1;
        rel_x       = '0;
        rel_y       = '0;
        rel_z       = '0;
        rel_h_x     = '0;
        rel_h_y     = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_angle_x", int'(angle_x), 0);
        chk("rst_angle_y", int'(angle_y), 0);
        chk("rst_view_valid", int'(view_valid), 0);
        chk("rst_view_x", int'(view_x), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        frame(0, 0, 0);

        send(127, 0);
        send(127, 0);
        send(96, 0);
        frame(350, 0, 0);
        send(20, 0);
        frame(10, 0, 0);

        send(-5, 80);
        frame(5, 80, 0);
        send(-10, 30);
        frame(355, 89, 0);
        send(0, -128);
        send(0, -46);
        frame(355, -85, 0);
        send(0, -20);
        frame(355, -89, 0);

        send(5, 0);
        frame(0, -89, 0);
        send(100, 127);
        send(100, 127);
        send(100, 0);
        send(100, 0);
        frame(359, 89, 0);

        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("clean_frame_idle", int'(busy), 0);

        send(1, 0);
        view_ready = 1'b0;
        frame(0, 89, 1);
        send(10, -9);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        chk("hold_busy", int'(busy), 1);
        chk("hold_valid", int'(view_valid), 1);
        chk("hold_angle_x", int'(angle_x), 0);
        chk("hold_view_x", int'(view_x), last_vx);
        view_ready = 1'b1;
        tick();
        chk("release_idle", int'(busy), 0);
        frame(10, 80, 0);

        send(50, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        chk("settle_busy", int'(busy), 1);
        chk("settle_angle_x", int'(angle_x), 60);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", int'(view_valid), 0);
        chk("mid_rst_angle_x", int'(angle_x), 0);
        chk("mid_rst_angle_y", int'(angle_y), 0);
        chk("mid_rst_busy", int'(busy), 0);
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (view_valid) begin
                vcnt++;
            end
        end
        chk("no_capture", vcnt, 0);
        frame(0, 0, 0);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
